aes_cipher_iter: RTL and testbench
==================================

Name: aes_cipher_iter

Overview:
- Iterative AES-128/192/256 encryption core.
- Reuses one round datapath for all rounds, NR = 10/12/14 selected by parameter.
- Sits between the block-level input FIFO and the ciphertext output stage, with valid/ready handshakes on both sides.
- Round keys come from an external round-key store, indexed combinationally by this block.

Parameters:
- KEY_BITS, 128, key length. Legal values: 128, 192, 256. NR = 10, 12, 14 respectively. Any other value is an elaboration error.
- RK_IDX_W, 4, width of the round-key index. Must satisfy 2^RK_IDX_W > NR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  core can accept plaintext.
- in_data  in  128  plaintext. Bit 127 is byte 0 of the FIPS-197 input.
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- rk_data  in  128  round key rk_idx. Valid combinationally in the same cycle.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  128  ciphertext. Same byte order as in_data.
- busy  out  1  high in ROUND state.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registers: st[127:0], rnd[RK_IDX_W-1:0].
- Reset (sync, rst=1 at an edge):
  - state=IDLE, rnd=0, st=0.
  - out_valid=0, busy=0, out_data=0.
  - in_ready=0 during rst. After release, in_ready=1.
  - rst has priority over all other inputs. Reset mid-ROUND or mid-DONE discards the block; no partial output is ever produced.
- rk_idx:
  - 0 in IDLE and DONE.
  - rnd in ROUND.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready at an edge):
  - st <= in_data ^ rk_data, using rk_idx=0 (initial AddRoundKey).
  - rnd <= 1, state <= ROUND.
- ROUND with rnd < NR:
  - st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk_data).
  - rnd <= rnd+1.
- ROUND with rnd == NR:
  - Final round, no MixColumns.
  - out_data <= result, out_valid <= 1, state <= DONE, rnd <= 0.
- DONE:
  - out_data is held stable while out_valid=1 & !out_ready.
  - out_valid & out_ready at an edge: out_valid <= 0.
    - If in_valid is high in the same cycle, accept new plaintext (state <= ROUND).
    - Otherwise state <= IDLE.
- Latency: out_valid rises exactly NR+1 edges after the accept edge.
- Throughput with out_ready held 1: one block per NR+1 cycles.
- in_data is sampled only at the accept edge; it may change afterwards.
- in_valid high in ROUND is ignored: in_ready=0, nothing is dropped.
- rk_data is sampled only at accept edges and in ROUND. The bench checks that rk_idx never exceeds NR.

Optional Feature:
- Macro: AES_CIPHER_ITER_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in ROUND or DONE: state <= IDLE, out_valid <= 0, rnd <= 0, st <= 0.
  - abort in IDLE has no effect.
  - abort has lower priority than rst and higher priority than accept/handshake. An abort in DONE drops the pending ciphertext even if out_ready=1 in that cycle.
- Undefined: no abort port. Behaviour exactly as above.

Decomposition:
- Shared package aes_pkg:
  - function nr_of(KEY_BITS) returning 10/12/14.
  - enum state_t {IDLE, ROUND, DONE}.
  - AES block width constant 128.
- One natural sub-module, aes_round_dp: combinational round datapath with a final_round input.
  - Built from the existing subBytes, shiftRows, mixColumns and addRoundKey blocks.
  - final_round=1 bypasses MixColumns.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: KEY_BITS=128, round keys from the bench key expansion of key 000102…0f; pt 00112233445566778899aabbccddeeff.
  - Response: out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 edges after accept.
- FIPS-197 C.2/C.3 vectors, same pt:
  - KEY_BITS=192 → dda97ca4864cdfe06eaf70a0ec0d7191, latency 13.
  - KEY_BITS=256 → 8ea2b7ca516745bfeafc49904b496089, latency 15.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises.
  - Response: out_data stable, in_ready=0, rk_idx=0 throughout; one transfer when out_ready=1.
- Back-to-back:
  - Stimulus: 4 blocks, in_valid and out_ready held 1.
  - Response: accepts spaced exactly NR+1 cycles apart; all 4 ciphertexts match the model, in order.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle at rnd=5.
  - Response: next cycle out_valid=0, busy=0, in_ready=1 after release; no output for the aborted block; the next block is correct.
- Abort (with AES_CIPHER_ITER_ABORT_EN defined):
  - Stimulus: abort in ROUND at rnd=3, and separately abort in DONE with out_ready=1.
  - Response: both blocks dropped; state returns to IDLE with out_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, block width, round-count lookup and
// the GF(2^8) helpers used to build the S-box arithmetically.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Returns 0 for an unsupported key length so the instantiating module can reject it.
    function automatic int unsigned nr_of(input int unsigned key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// final_round is set) and AddRoundKey. Byte i of the state sits at bits [127-8i -: 8].
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] st_in,
    input  logic [AES_BLOCK_W-1:0] rk_in,
    input  logic                   final_round,
    output logic [AES_BLOCK_W-1:0] st_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st_in[127-8*i -: 8]);
        end
    end

    // State is column-major: byte index = row + 4*col; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)&3)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        st_out = '0;
        for (int i = 0; i < 16; i++) begin
            st_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ rk_in[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core reusing one round datapath.
// Optional abort input enabled by defining AES_CIPHER_ITER_ABORT_EN.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128,
    parameter int unsigned RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef AES_CIPHER_ITER_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int unsigned NR = nr_of(KEY_BITS);
    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    if (NR == 0) begin : g_bad_key_bits
        $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
    end
    if ((1 << RK_IDX_W) <= NR) begin : g_bad_rk_idx_w
        $error("aes_cipher_iter: RK_IDX_W too narrow to index round NR");
    end

    state_t                 state_q, state_d;
    logic [RK_IDX_W-1:0]    rnd_q, rnd_d;
    logic [AES_BLOCK_W-1:0] st_q, st_d;
    logic [AES_BLOCK_W-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic                   final_round;
    logic [AES_BLOCK_W-1:0] round_out;

    assign final_round = (rnd_q == NR_IDX);

    aes_round_dp u_round_dp (
        .st_in       (st_q),
        .rk_in       (rk_data),
        .final_round (final_round),
        .st_out      (round_out)
    );

    // rst gates in_ready so nothing is accepted while reset is asserted.
    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign rk_idx    = (state_q == ROUND) ? rnd_q : '0;
    assign busy      = (state_q == ROUND);
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // rk_idx is 0 outside ROUND, so rk_data is the whitening key here.
                    st_d    = in_data ^ rk_data;
                    rnd_d   = RK_IDX_W'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_out;
                if (final_round) begin
                    out_d       = round_out;
                    out_valid_d = 1'b1;
                    rnd_d       = '0;
                    state_d     = DONE;
                end else begin
                    rnd_d = rnd_q + RK_IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        st_d    = in_data ^ rk_data;
                        rnd_d   = RK_IDX_W'(1);
                        state_d = ROUND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AES_CIPHER_ITER_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            rnd_d       = '0;
            st_d        = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: three instances (AES-128/192/256)
// checked against a byte-array AES model with its own key expansion.
module tb_aes_cipher_iter;

    localparam int NI = 3;

    typedef struct {
        int           g;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NI-1:0]   in_valid, in_ready, out_valid, out_ready, busy;
`ifdef AES_CIPHER_ITER_ABORT_EN
    logic [NI-1:0]   abort;
`endif
    logic [127:0]    in_data  [NI];
    logic [127:0]    rk_data  [NI];
    logic [127:0]    out_data [NI];
    logic [3:0]      rk_idx   [NI];
    logic [127:0]    rk_tbl   [NI][16];
    logic [7:0]      sbox_t   [256];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_cipher_iter #(.KEY_BITS(128 + 64 * g), .RK_IDX_W(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
`ifdef AES_CIPHER_ITER_ABORT_EN
            .abort     (abort[g]),
`endif
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .rk_idx    (rk_idx[g]),
            .rk_data   (rk_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
        assign rk_data[g] = rk_tbl[g][rk_idx[g]];
    end

    function automatic int nr_g(input int g);
        return 10 + 2 * g;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box by brute-force search for the multiplicative inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
                        ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic expand(input int g, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * g;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk_tbl[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    function automatic logic [127:0] model_enc(input int g, input logic [127:0] pt);
        logic [127:0] s;
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_tbl[g][0];
        for (int r = 1; r <= nr_g(g); r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
            if (r < nr_g(g)) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    t[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s = s ^ rk_tbl[g][r];
        end
        return s;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rk_idx must stay within 0..NR and be 0 whenever the core is not in ROUND.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int g = 0; g < NI; g++) begin
                if (rk_idx[g] > nr_g(g) || (!busy[g] && rk_idx[g] != 0)) begin
                    errs++;
                    $display("FAIL rk_idx inst%0d: got %0d busy %0b", g, rk_idx[g], busy[g]);
                end
            end
        end
    end

    task automatic wait_valid(input int g, input string nm);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid[g]) seen = 1;
            else tick();
        end
        chk({nm, " out_valid rise"}, 128'(seen), 128'd1);
    endtask

    task automatic run_block(input int g, input logic [127:0] pt, input logic [127:0] exp,
                             input string nm);
        int acc;
        in_data[g]   = pt;
        in_valid[g]  = 1'b1;
        out_ready[g] = 1'b1;
        #1;
        chk({nm, " in_ready"}, 128'(in_ready[g]), 128'd1);
        tick();
        acc = cyc;
        in_valid[g] = 1'b0;
        in_data[g]  = r128();
        wait_valid(g, nm);
        // edges counted including the accept edge itself
        chk({nm, " latency"}, 128'(cyc - acc + 1), 128'(nr_g(g) + 1));
        chk({nm, " ct"}, out_data[g], exp);
        tick();
        chk({nm, " out_valid drop"}, 128'(out_valid[g]), 128'd0);
        chk({nm, " back to idle"}, 128'(in_ready[g]), 128'd1);
    endtask

    task automatic quiet(input int g, input int n, input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (out_valid[g] || busy[g]) bad++;
        end
        chk({nm, " no output"}, 128'(bad), 128'd0);
    endtask

    task automatic accept_one(input int g, input logic [127:0] pt);
        in_data[g]  = pt;
        in_valid[g] = 1'b1;
        tick();
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_rnd(input int g, input int n, input string nm);
        for (int k = 0; k < 20 && rk_idx[g] != n; k++) tick();
        chk({nm, " rk_idx"}, 128'(rk_idx[g]), 128'(n));
    endtask

    // ---------------- test sequences ----------------
    task automatic test_backpressure();
        logic [127:0] pt, exp;
        int bad;
        pt  = r128();
        exp = model_enc(0, pt);
        out_ready[0] = 1'b1;
        accept_one(0, pt);
        wait_valid(0, "bp");
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = r128();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!out_valid[0] || out_data[0] !== exp || in_ready[0] || rk_idx[0] != 0
                || busy[0]) bad++;
        end
        chk("bp hold bad cycles", 128'(bad), 128'd0);
        chk("bp ct", out_data[0], exp);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("bp transfer", 128'(out_valid[0]), 128'd0);
        chk("bp idle", 128'(busy[0]), 128'd0);
    endtask

    task automatic test_b2b();
        logic [127:0] q[$];
        int           acc_cyc[$];
        int           n_acc, n_rx;
        bit           xfer, acc;
        n_acc = 0;
        n_rx  = 0;
        in_data[0]   = r128();
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 200 && n_rx < 4; k++) begin
            #1;
            xfer = out_valid[0] && out_ready[0];
            acc  = in_valid[0] && in_ready[0];
            if (xfer) begin
                if (q.size() > 0) chk("b2b ct", out_data[0], q.pop_front());
                else chk("b2b unexpected output", 128'd1, 128'd0);
                n_rx++;
            end
            tick();
            if (acc) begin
                q.push_back(model_enc(0, in_data[0]));
                acc_cyc.push_back(cyc);
                n_acc++;
                if (n_acc < 4) in_data[0] = r128();
                else in_valid[0] = 1'b0;
            end
        end
        chk("b2b blocks", 128'(n_rx), 128'd4);
        if (acc_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(nr_g(0) + 1));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        accept_one(0, r128());
        wait_rnd(0, 5, "rst");
        rst = 1'b1;
        tick();
        chk("rst in_ready low", 128'(in_ready[0]), 128'd0);
        chk("rst out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst busy", 128'(busy[0]), 128'd0);
        rst = 1'b0;
        #1;
        chk("rst in_ready after", 128'(in_ready[0]), 128'd1);
        quiet(0, 20, "rst");
        pt = r128();
        run_block(0, pt, model_enc(0, pt), "post-rst");
    endtask

`ifdef AES_CIPHER_ITER_ABORT_EN
    task automatic test_abort();
        logic [127:0] pt;
        accept_one(0, r128());
        wait_rnd(0, 3, "abort round");
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort round out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort round busy", 128'(busy[0]), 128'd0);
        chk("abort round in_ready", 128'(in_ready[0]), 128'd1);
        quiet(0, 20, "abort round");
        out_ready[0] = 1'b1;
        accept_one(0, r128());
        wait_valid(0, "abort done");
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort done out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort done busy", 128'(busy[0]), 128'd0);
        chk("abort done in_ready", 128'(in_ready[0]), 128'd1);
        quiet(0, 20, "abort done");
        pt = r128();
        run_block(0, pt, model_enc(0, pt), "post-abort");
    endtask
`endif

    vec_t tbl [9];

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
`ifdef AES_CIPHER_ITER_ABORT_EN
        abort     = '0;
`endif
        for (int g = 0; g < NI; g++) in_data[g] = '0;
        build_sbox();

        tbl[0].g = 0; tbl[0].key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        tbl[0].pt = 128'h00112233445566778899aabbccddeeff;
        tbl[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tbl[1].g = 1; tbl[1].key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        tbl[1].pt = 128'h00112233445566778899aabbccddeeff;
        tbl[1].ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        tbl[2].g = 2;
        tbl[2].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        tbl[2].pt = 128'h00112233445566778899aabbccddeeff;
        tbl[2].ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int i = 3; i < 9; i++) begin
            tbl[i].g   = i % 3;
            tbl[i].key = {r128(), r128()};
            tbl[i].pt  = r128();
            expand(tbl[i].g, tbl[i].key);
            tbl[i].ct  = model_enc(tbl[i].g, tbl[i].pt);
        end
        for (int g = 0; g < NI; g++) expand(g, tbl[g].key);

        tick();
        tick();
        chk("reset in_ready", 128'(in_ready), 128'd0);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset out_data", out_data[0], 128'd0);
        chk("reset rk_idx", 128'(rk_idx[0]), 128'd0);
        rst = 1'b0;
        #1;
        chk("release in_ready", 128'(in_ready), 128'd7);
        mon_en = 1;

        for (int i = 0; i < 9; i++) begin
            expand(tbl[i].g, tbl[i].key);
            run_block(tbl[i].g, tbl[i].pt, tbl[i].ct, $sformatf("vec%0d", i));
        end

        test_backpressure();
        test_b2b();
        test_reset_mid();
`ifdef AES_CIPHER_ITER_ABORT_EN
        test_abort();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
